// File: rtl/camera64x64_frame_reader.sv
// Host-side SPI master for the 64x64 camera: trigger burst, wait for INT, read one
// frame and stream its bytes out. States: IDLE idle | TRIG trigger burst |
// WAIT_INT wait for camera | READ frame burst | FIN done pulse | ERR timeout pulse.
module camera64x64_frame_reader #(
  parameter int          CLK_DIV    = 4,
  parameter int          TRIG_BYTES = 1,
  parameter int          NPIX       = 4096,
  parameter logic [31:0] TIMEOUT    = 32'd480000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       INT,
  input  logic       MISO,
  output logic       SCLK,
  output logic       CS_N,
  output logic [7:0] PIX_DATA,
  output logic       PIX_VALID,
  output logic       PIX_LAST,
  output logic       BUSY,
  output logic       DONE,
  output logic       TIMEOUT_ERR
);

  localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TRIG_EDGES = 16 * TRIG_BYTES;
  localparam int READ_EDGES = 16 * NPIX;
  localparam int MAX_EDGES  = (TRIG_EDGES > READ_EDGES) ? TRIG_EDGES : READ_EDGES;
  localparam int EW         = $clog2(MAX_EDGES + 1);
  localparam int PW         = $clog2(NPIX + 1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_INT, READ, FIN, ERR} state_t;

  state_t          state;
  logic            int_meta;
  logic            int_s;
  logic [DW-1:0]   div_cnt;
  logic [EW-1:0]   edge_cnt;
  logic [EW-1:0]   edge_lim;
  logic [2:0]      bit_cnt;
  logic [7:0]      sreg;
  logic            byte_done;
  logic [PW-1:0]   pix_cnt;
  logic [31:0]     tmo_cnt;

  assign edge_lim = (state == TRIG) ? EW'(TRIG_EDGES) : EW'(READ_EDGES);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      int_meta <= 1'b0;
      int_s    <= 1'b0;
    end else begin
      int_meta <= INT;
      int_s    <= int_meta;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      SCLK        <= 1'b0;
      CS_N        <= 1'b1;
      PIX_DATA    <= 8'h00;
      PIX_VALID   <= 1'b0;
      PIX_LAST    <= 1'b0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      div_cnt     <= '0;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      sreg        <= '0;
      byte_done   <= 1'b0;
      pix_cnt     <= '0;
      tmo_cnt     <= '0;
    end else begin
      PIX_VALID   <= 1'b0;
      PIX_LAST    <= 1'b0;
      DONE        <= 1'b0;
      TIMEOUT_ERR <= 1'b0;
      byte_done   <= 1'b0;

      if (byte_done) begin
        PIX_DATA  <= sreg;
        PIX_VALID <= 1'b1;
        PIX_LAST  <= (pix_cnt == PW'(NPIX - 1));
        pix_cnt   <= pix_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (START) begin
            state    <= TRIG;
            CS_N     <= 1'b0;
            BUSY     <= 1'b1;
            SCLK     <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
          end
        end

        TRIG, READ: begin
          if (div_cnt == DW'(CLK_DIV - 1)) begin
            div_cnt <= '0;
            // Extra half-period after the last falling edge before CS_N rises.
            if (edge_cnt == edge_lim) begin
              CS_N     <= 1'b1;
              edge_cnt <= '0;
              if (state == TRIG) begin
                state   <= WAIT_INT;
                tmo_cnt <= '0;
              end else begin
                state <= FIN;
                DONE  <= 1'b1;
              end
            end else begin
              SCLK     <= ~SCLK;
              edge_cnt <= edge_cnt + 1'b1;
              if (!SCLK) begin
                sreg    <= {sreg[6:0], MISO};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7 && state == READ)
                  byte_done <= 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        WAIT_INT: begin
          // A synchronised INT takes priority over the terminal count.
          if (int_s) begin
            state    <= READ;
            CS_N     <= 1'b0;
            tmo_cnt  <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            bit_cnt  <= '0;
          end else if (tmo_cnt == TIMEOUT - 32'd1) begin
            state       <= ERR;
            TIMEOUT_ERR <= 1'b1;
            tmo_cnt     <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        FIN, ERR: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          CS_N  <= 1'b1;
          SCLK  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_camera64x64_frame_reader.sv
// Scoreboard bench for camera64x64_frame_reader with a behavioural SPI camera model.
module tb_camera64x64_frame_reader;
  localparam int          CD   = 2;
  localparam int          NPIX = 16;
  localparam logic [31:0] TMO  = 32'd1000;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       INT = 1'b0;
  logic       MISO = 1'b0;
  logic       SCLK, CS_N, PIX_VALID, PIX_LAST, BUSY, DONE, TIMEOUT_ERR;
  logic [7:0] PIX_DATA;

  camera64x64_frame_reader #(.CLK_DIV(CD), .TRIG_BYTES(1), .NPIX(NPIX), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .INT(INT), .MISO(MISO),
    .SCLK(SCLK), .CS_N(CS_N), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .PIX_LAST(PIX_LAST), .BUSY(BUSY), .DONE(DONE), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [7:0] d; logic l; } pix_t;
  pix_t exp_q[$];

  int checks = 0, errors = 0;
  int pix_seen = 0, done_cnt = 0, tmo_seen = 0, idle_viol = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Camera: presents MSB first, shifts on falling SCLK, frame data only when armed by INT.
  logic [7:0] frame [NPIX];
  bit         cam_read = 1'b0;
  int         cb_bit, cb_byte;
  logic [7:0] tx;

  always @(negedge CS_N) begin
    cb_bit  = 0;
    cb_byte = 0;
    tx      = cam_read ? frame[0] : 8'($urandom);
    MISO    = tx[7];
  end

  always @(negedge SCLK) begin
    if (!CS_N) begin
      cb_bit++;
      if (cb_bit == 8) begin
        cb_bit = 0;
        cb_byte++;
        tx = (cam_read && cb_byte < NPIX) ? frame[cb_byte] : 8'($urandom);
      end
      MISO = tx[7-cb_bit];
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (CS_N && SCLK) idle_viol++;
      if (PIX_VALID) begin
        pix_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %02h with no pixel expected", PIX_DATA);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("pix_data", PIX_DATA, e.d);
          chk("pix_last", PIX_LAST, e.l);
        end
      end
      if (DONE) done_cnt++;
      if (TIMEOUT_ERR) tmo_seen++;
    end
  end

  task automatic load_frame(input bit incr);
    pix_t p;
    for (int i = 0; i < NPIX; i++) begin
      frame[i] = incr ? 8'(i) : 8'($urandom);
      p.d = frame[i];
      p.l = (i == NPIX - 1);
      exp_q.push_back(p);
    end
  endtask

  task automatic pulse_start();
    @(posedge CLK); #1 START = 1'b1;
    @(posedge CLK); #1 START = 1'b0;
  endtask

  // Starts a frame and checks the trigger burst waveform; returns aligned to WAIT_INT entry.
  task automatic trig_phase();
    int mism = 0;
    cam_read = 1'b0;
    INT = 1'b0;
    pulse_start();
    chk("cs_fall_on_trig_entry", CS_N, 1'b0);
    chk("busy_in_trig", BUSY, 1'b1);
    for (int k = 1; k <= 17 * CD; k++) begin
      @(posedge CLK); #1;
      if (k < 16 * CD) begin
        if (SCLK !== 1'(((k / CD) % 2))) mism++;
      end else if (SCLK !== 1'b0) mism++;
      if (CS_N !== ((k == 17 * CD) ? 1'b1 : 1'b0)) mism++;
    end
    chk("trig_wave_mismatches", mism, 0);
  endtask

  task automatic wait_cs(input logic lvl, input int lim, input string name);
    int n = 0;
    while (CS_N !== lvl && n < lim) begin
      @(posedge CLK); #1;
      n++;
    end
    chk(name, CS_N, lvl);
  endtask

  task automatic finish_frame(input int d0, input int t0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("done_count", done_cnt - d0, 1);
    chk("frame_queue_empty", exp_q.size(), 0);
    chk("no_timeout_in_frame", tmo_seen - t0, 0);
    chk("busy_low_after_done", BUSY, 1'b0);
  endtask

  task automatic normal_frame(input bit incr, input int int_delay, input bit restart);
    int d0 = done_cnt;
    int t0 = tmo_seen;
    load_frame(incr);
    trig_phase();
    repeat (int_delay) @(posedge CLK);
    #1 cam_read = 1'b1;
    INT = 1'b1;
    wait_cs(1'b0, 10, "read_cs_fall");
    INT = 1'b0;
    if (restart) begin
      repeat (100) @(posedge CLK);
      #1 START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
    end
    finish_frame(d0, t0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, t0, p0, n;
    repeat (3) @(posedge CLK);
    #1 chk("reset_outputs", {SCLK, CS_N, PIX_DATA, PIX_VALID, PIX_LAST, BUSY, DONE, TIMEOUT_ERR},
           {1'b0, 1'b1, 8'h00, 5'b0});
    RST = 1'b0;
    repeat (2) @(posedge CLK);

    // Incrementing frame, INT 200 cycles after trigger.
    normal_frame(1'b1, 200, 1'b0);

    // INT held low: timeout exactly TMO cycles after WAIT_INT entry.
    p0 = pix_seen; t0 = tmo_seen;
    trig_phase();
    repeat (TMO - 1) @(posedge CLK);
    #1 chk("no_timeout_before_tc", TIMEOUT_ERR, 1'b0);
    @(posedge CLK); #1;
    chk("timeout_pulse", TIMEOUT_ERR, 1'b1);
    @(posedge CLK); #1;
    chk("busy_low_after_err", BUSY, 1'b0);
    chk("timeout_single_pulse", tmo_seen - t0, 1);
    chk("no_pixels_on_timeout", pix_seen - p0, 0);

    // START during READ is ignored.
    normal_frame(1'b0, 20 + $urandom_range(0, 60), 1'b1);
    repeat (40) @(posedge CLK);
    #1 chk("no_restart_cs", CS_N, 1'b1);
    chk("no_restart_busy", BUSY, 1'b0);

    // Reset after pixel 7, then a full frame.
    d0 = done_cnt; p0 = pix_seen;
    load_frame(1'b0);
    trig_phase();
    repeat (30) @(posedge CLK);
    #1 cam_read = 1'b1;
    INT = 1'b1;
    wait_cs(1'b0, 10, "read_cs_fall_rst");
    INT = 1'b0;
    n = 0;
    while (pix_seen - p0 < 7 && n < 2000) begin
      @(negedge CLK);
      n++;
    end
    chk("pixels_before_rst", pix_seen - p0, 7);
    #2 RST = 1'b1;
    #1 chk("rst_midburst_outputs", {SCLK, CS_N, PIX_DATA, PIX_VALID, PIX_LAST, BUSY, DONE, TIMEOUT_ERR},
           {1'b0, 1'b1, 8'h00, 5'b0});
    chk("no_partial_done", done_cnt - d0, 0);
    exp_q.delete();
    @(posedge CLK); #1 RST = 1'b0;
    normal_frame(1'b0, 50, 1'b0);

    // INT synchronised on the terminal-count cycle: READ wins.
    d0 = done_cnt; t0 = tmo_seen;
    load_frame(1'b0);
    trig_phase();
    repeat (TMO - 3) @(posedge CLK);
    #1 cam_read = 1'b1;
    INT = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk("still_waiting_at_tc", CS_N, 1'b1);
    @(posedge CLK); #1;
    chk("int_wins_read_entered", CS_N, 1'b0);
    chk("int_wins_no_timeout", TIMEOUT_ERR, 1'b0);
    INT = 1'b0;
    finish_frame(d0, t0);

    // INT one cycle too late: timeout.
    t0 = tmo_seen;
    trig_phase();
    repeat (TMO - 2) @(posedge CLK);
    #1 INT = 1'b1;
    repeat (2) @(posedge CLK);
    #1 chk("late_int_timeout", TIMEOUT_ERR, 1'b1);
    INT = 1'b0;
    repeat (5) @(posedge CLK);
    #1 chk("late_int_idle", BUSY, 1'b0);
    chk("late_int_single_pulse", tmo_seen - t0, 1);

    // Final random frame.
    normal_frame(1'b0, $urandom_range(0, 40), 1'b0);

    chk("sclk_high_while_cs_high", idle_viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
